// File: rtl/layer_pkg.sv
// Shared definitions for the layer trainer and the forward layer.
// Holds the trainer FSM state type and the fixed-point helpers:
//   round_shr : arithmetic right shift, rounding half away from zero
//   sat_s     : clamp a value to a signed range of the given width
package layer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        PULSE,
        GAP,
        DONE
    } state_t;

    // Divide by 2^s, rounding half away from zero. The magnitude is rounded
    // first and the sign is put back afterwards, so negative ties move away
    // from zero.
    function automatic logic signed [63:0] round_shr(input logic signed [63:0] v,
                                                     input int s);
        logic signed [63:0] half;
        logic signed [63:0] mag;
        if (s <= 0) return v;
        half = 64'sd1 <<< (s - 1);
        mag  = (v < 0) ? -v : v;
        mag  = (mag + half) >>> s;
        return (v < 0) ? -mag : mag;
    endfunction

    // Clamp to [-2^(w-1), 2^(w-1)-1].
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                 input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/layer_trainer_if.sv
// Bus between a training controller (master) and the layer trainer (slave).
//   start/values/errors          : request one pass with the given operands
//   row_sel/weight_update/
//   bias_updates/train_en        : per-row update presented to the layer
//   busy/done                    : pass status
interface layer_trainer_if #(
    parameter int rows        = 30,
    parameter int columns     = 64,
    parameter int max_rows    = 30,
    parameter int max_columns = 64,
    parameter int datawidth   = 11
);
    logic                                      start;
    logic signed [columns*datawidth-1:0]       values;
    logic signed [rows*2*datawidth-1:0]        errors;
    logic        [$clog2(max_rows)-1:0]        row_sel;
    logic signed [max_columns*datawidth-1:0]   weight_update;
    logic signed [max_rows*2*datawidth-1:0]    bias_updates;
    logic                                      train_en;
    logic                                      busy;
    logic                                      done;

    modport master (
        output start, values, errors,
        input  row_sel, weight_update, bias_updates, train_en, busy, done
    );

    modport slave (
        input  start, values, errors,
        output row_sel, weight_update, bias_updates, train_en, busy, done
    );
endinterface

// File: rtl/layer_trainer_grad_row_unit.sv
// Combinational gradient step for one neuron row.
//   delta_i  : row error delta (2*datawidth, signed)
//   values_i : input activations, column j at [(columns-1-j)*datawidth]
//   weight_o : per-column weight delta, slot j at [(max_columns-1-j)*datawidth];
//              slots at or beyond columns are zero
//   bias_o   : row bias delta (2*datawidth, signed)
module grad_row_unit
    import layer_pkg::*;
#(
    parameter int columns     = 64,
    parameter int max_columns = 64,
    parameter int datawidth   = 11,
    parameter int frac_bits   = 8,
    parameter int lr_shift    = 2
) (
    input  logic signed [2*datawidth-1:0]           delta_i,
    input  logic signed [columns*datawidth-1:0]     values_i,
    output logic signed [max_columns*datawidth-1:0] weight_o,
    output logic signed [2*datawidth-1:0]           bias_o
);
    localparam int DW = datawidth;
    localparam int EW = 2 * datawidth;
    localparam int PW = 3 * datawidth;

    for (genvar j = 0; j < max_columns; j++) begin : g_col
        if (j < columns) begin : g_active
            logic signed [DW-1:0] x;
            logic signed [PW-1:0] prod;
            logic signed [63:0]   w64;
            logic                 unused_hi;

            assign x    = values_i[(columns-1-j)*DW +: DW];
            // Exact product: 2*DW x DW bits never exceeds 3*DW bits.
            assign prod = PW'(delta_i) * PW'(x);
            assign w64  = sat_s(round_shr(-(64'(prod)), frac_bits + lr_shift), DW);
            assign weight_o[(max_columns-1-j)*DW +: DW] = w64[DW-1:0];
            // Above DW the saturated value is only sign extension.
            assign unused_hi = ^w64[63:DW];
        end else begin : g_idle
            assign weight_o[(max_columns-1-j)*DW +: DW] = '0;
        end
    end

    logic signed [63:0] b64;
    logic               unused_bhi;

    assign b64        = sat_s(round_shr(-(64'(delta_i)), lr_shift), EW);
    assign bias_o     = b64[EW-1:0];
    assign unused_bhi = ^b64[63:EW];
endmodule

// File: rtl/layer_trainer.sv
// Layer trainer: walks the rows of a layer, computing one gradient step per
// row and presenting it to the layer with a single train_en strobe followed
// by a quiet cycle, so the layer always sees a fresh rising edge per row.
// Rows with a zero error delta are skipped without a strobe.
//   clk           : rising-edge clock
//   rst_overall_n : asynchronous active-low reset
//   bus           : layer_trainer_if slave (start/values/errors in,
//                   row_sel/weight_update/bias_updates/train_en/busy/done out)
module layer_trainer
    import layer_pkg::*;
#(
    parameter int rows        = 30,
    parameter int columns     = 64,
    parameter int max_rows    = 30,
    parameter int max_columns = 64,
    parameter int datawidth   = 11,
    parameter int frac_bits   = 8,
    parameter int lr_shift    = 2
) (
    input  logic             clk,
    input  logic             rst_overall_n,
    layer_trainer_if.slave   bus
);
    localparam int DW  = datawidth;
    localparam int EW  = 2 * datawidth;
    localparam int RSW = $clog2(max_rows);

    state_t                            state_q, state_d;
    logic        [RSW-1:0]             r_q, r_d;
    logic signed [columns*DW-1:0]      values_q;
    logic signed [rows*EW-1:0]         errors_q;
    logic        [RSW-1:0]             row_sel_q;
    logic signed [max_columns*DW-1:0]  weight_q;
    logic signed [max_rows*EW-1:0]     bias_q;
    logic                              train_en_q, busy_q, done_q;

    logic signed [EW-1:0]              delta_r;
    logic signed [max_columns*DW-1:0]  weight_row;
    logic signed [EW-1:0]              bias_row;
    logic signed [max_rows*EW-1:0]     bias_vec;
    logic                              last_row, latch, load;

    always_comb begin
        delta_r = errors_q[(rows-1-int'(r_q))*EW +: EW];
    end

    grad_row_unit #(
        .columns     (columns),
        .max_columns (max_columns),
        .datawidth   (datawidth),
        .frac_bits   (frac_bits),
        .lr_shift    (lr_shift)
    ) u_grad (
        .delta_i  (delta_r),
        .values_i (values_q),
        .weight_o (weight_row),
        .bias_o   (bias_row)
    );

    // Only the selected row's slot carries a value; every other slot is zero.
    always_comb begin
        bias_vec = '0;
        bias_vec[(max_rows-1-int'(r_q))*EW +: EW] = bias_row;
    end

    assign last_row = (r_q == RSW'(rows - 1));

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        latch   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    r_d     = '0;
                    latch   = 1'b1;
                end
            end
            CALC: begin
                if (delta_r == '0) begin
                    if (last_row) state_d = DONE;
                    else          r_d     = r_q + RSW'(1);
                end else begin
                    load    = 1'b1;
                    state_d = PULSE;
                end
            end
            PULSE: state_d = GAP;
            GAP: begin
                if (last_row) begin
                    state_d = DONE;
                end else begin
                    r_d     = r_q + RSW'(1);
                    state_d = CALC;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            values_q   <= '0;
            errors_q   <= '0;
            row_sel_q  <= '0;
            weight_q   <= '0;
            bias_q     <= '0;
            train_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            if (latch) begin
                values_q <= bus.values;
                errors_q <= bus.errors;
            end
            // Update outputs are held from here through PULSE and GAP.
            if (load) begin
                row_sel_q <= r_q;
                weight_q  <= weight_row;
                bias_q    <= bias_vec;
            end
            // Registered strobes: train_en tracks PULSE exactly, done follows
            // the DONE state by one cycle, busy drops as done rises.
            train_en_q <= (state_d == PULSE);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_q == DONE);
        end
    end

    assign bus.row_sel       = row_sel_q;
    assign bus.weight_update = weight_q;
    assign bus.bias_updates  = bias_q;
    assign bus.train_en      = train_en_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule

// File: doc/layer_trainer.md
LAYER_TRAINER -- requirements
Module: layer_trainer

Interface
REQ-001 Parameter rows, default 30: number of active neuron rows driven.
REQ-002 Parameter columns, default 64: number of active inputs per row.
REQ-003 Parameter max_rows, default 30, and max_columns, default 64: bus sizing of the target layer.
REQ-004 Parameter datawidth, default 11: activation/weight width; errors and biases are 2*datawidth.
REQ-005 Parameter frac_bits, default 8, and lr_shift, default 2: fixed-point fraction bits and learning-rate shift.
REQ-006 Port list: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_overall_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  request one training pass; sampled only in IDLE.
REQ-010 values  in  columns*datawidth signed  input activations; column j at [(columns-1-j)*datawidth +: datawidth].
REQ-011 errors  in  rows*2*datawidth signed  per-row output error delta; row r at [(rows-1-r)*2*datawidth +: 2*datawidth].
REQ-012 row_sel  out  $clog2(max_rows)  row being updated.
REQ-013 weight_update  out  max_columns*datawidth signed  per-column weight delta, same slot order as values.
REQ-014 bias_updates  out  max_rows*2*datawidth signed  per-row bias delta, same slot order as errors.
REQ-015 train_en  out  1  one-cycle update strobe to the layer.
REQ-016 busy  out  1  high from the cycle after accepted start until done.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 FSM states IDLE, CALC, PULSE, GAP, DONE; IDLE->CALC on start, latching values and errors and clearing row counter r.
REQ-019 CALC: if delta_r == 0, the row is skipped (r++, remain in CALC, or go DONE if r == rows-1); otherwise register the updates for row r, go PULSE.
REQ-020 Weight update column j = sat_dw(round(-(delta_r*x_j) / 2^(frac_bits+lr_shift))); product at full 3*datawidth width; rounding half away from zero; saturation to [-2^(datawidth-1), 2^(datawidth-1)-1].
REQ-021 Bias update for row r = sat_2dw(round(-delta_r / 2^lr_shift)), same rounding, saturated to 2*datawidth.
REQ-022 bias_updates carries the row-r value in slot r only; all other slots, including slots >= rows, are zero whenever train_en is high.
REQ-023 weight_update slots for columns >= columns are zero.
REQ-024 PULSE: train_en=1 for exactly one cycle, row_sel=r; go GAP.
REQ-025 GAP: train_en=0 for one cycle (guarantees a fresh rising edge per row); row_sel, weight_update and bias_updates are held stable through PULSE and GAP; then r++ and CALC, or DONE after row rows-1.
REQ-026 DONE: done=1 for one cycle, busy=0, next state IDLE.
REQ-027 Latency with no skipped rows: done asserts 3*rows+1 cycles after the start-accepting edge; each skipped row saves 2 cycles.
REQ-028 start while not IDLE is ignored; values and errors changing mid-pass have no effect.
REQ-029 All-zero errors: no train_en pulse; done after rows+1 cycles.

Reset
REQ-030 Assertion of rst_overall_n low immediately forces IDLE; train_en, done and busy = 0; row_sel, weight_update and bias_updates = 0; latched operands cleared.
REQ-031 Reset mid-pass abandons the pass; no further train_en until a new start after release.

Structure
REQ-032 Shared package layer_pkg holds the state typedef and the rounding/saturation helper functions, reused by the forward layer.
REQ-033 One sub-module, grad_row_unit: combinational per-row weight-delta vector and bias-delta calculation (REQ-020/021); the FSM lives in layer_trainer.

Verification
REQ-034 rows=2, columns=2, dw=11: delta=256, x=256 (both), start -> row0 weight_update 0x7C0 (-64) per column, bias slot0 -64, one train_en; same for row1; done at cycle 7.
REQ-035 delta_0 = 2^21-1, x_0 = -1024 -> weight column0 saturates to +1023; bias saturates/rounds to -524288.
REQ-036 errors all zero -> train_en never high; done after rows+1 cycles.
REQ-037 delta_0 = 0, delta_1 = -256 -> single pulse with row_sel=1, bias slot1 +64, slot0 0.
REQ-038 start held high during pass -> exactly one pass; reset low in PULSE -> train_en drops asynchronously, FSM IDLE, outputs zero.
REQ-039 Connect to the forward layer: after one pass, the layer's bias_values[r] equal the computed bias deltas and the other rows are unchanged.
